// File: rtl/hwpe_ctrl_uloop_master_pkg.sv
// Shared types for the uloop master: uloop control/flag bundles, the
// buffered command format and the master FSM state encoding.
package hwpe_ctrl_package;

   localparam int unsigned ULOOP_MAX_NB_LOOPS     = 6;
   localparam int unsigned ULOOP_MAX_NB_REG       = 4;
   localparam int unsigned ULOOP_MAX_REG_WIDTH    = 32;
   localparam int unsigned ULOOP_MAX_IDX_WIDTH    = 16;
   localparam int unsigned ULOOP_DEFAULT_SHADOWED = 1;

   typedef struct packed {
      logic enable;
      logic clear;
      logic ready;
   } ctrl_uloop_t;

   typedef struct packed {
      logic                                                 valid;
      logic                                                 done;
      logic                                                 ready;
      logic [ULOOP_MAX_NB_REG-1:0][ULOOP_MAX_REG_WIDTH-1:0] offs;
      logic [ULOOP_MAX_NB_LOOPS-1:0][ULOOP_MAX_IDX_WIDTH-1:0] idx;
      logic [ULOOP_MAX_NB_LOOPS-1:0]                        idx_update;
   } flags_uloop_t;

   typedef struct packed {
      logic [ULOOP_MAX_NB_REG-1:0][ULOOP_MAX_REG_WIDTH-1:0] offs;
      logic [ULOOP_MAX_NB_LOOPS-1:0]                        idx_update;
      logic                                                 last;
   } uloop_cmd_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      REQ   = 3'd2,
      WAIT  = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } uloop_master_state_t;

endpackage

// File: rtl/hwpe_ctrl_uloop_master_cmd_fifo.sv
// First-word-fall-through command buffer for the uloop master.
// Head data reads as zero while empty so a cleared/reset FIFO shows all-zero outputs.
module hwpe_ctrl_uloop_cmd_fifo
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_clear,
   input  logic                              i_push,
   input  uloop_cmd_t                        i_data,
   input  logic                              i_pop,
   output logic                              o_valid,
   output logic                              o_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
   output uloop_cmd_t                        o_data
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

   uloop_cmd_t        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign w_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign o_valid = ~w_empty;
   assign o_count = r_count;
   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

   assign w_pop  = i_pop & ~w_empty & ~i_clear;
   assign w_push = i_push & ~i_clear & (~o_full | w_pop);

   // Read/write pointers, wrapping modulo the depth.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else if (i_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
   end

   // Occupancy; simultaneous push and pop leave it unchanged.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage write; contents need no reset since the head is masked while empty.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(i_push && !i_clear && o_full && !i_pop))
      else $error("uloop command FIFO overflow");

endmodule

// File: rtl/hwpe_ctrl_uloop_master.sv
// uloop initiator: sequences enable/clear toward the uloop, turns every
// produced iteration into a buffered command and streams commands out.
// Optional watchdog on the WAIT state: define HWPE_CTRL_ULOOP_MASTER_TIMEOUT_EN.
module hwpe_ctrl_uloop_master
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned NB_REG         = ULOOP_MAX_NB_REG,
   parameter int unsigned REG_WIDTH      = ULOOP_MAX_REG_WIDTH,
   parameter int unsigned NB_LOOPS       = ULOOP_MAX_NB_LOOPS,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned SHADOWED       = ULOOP_DEFAULT_SHADOWED,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        test_mode_i,
   input  logic                        clear_i,
   input  logic                        start_i,
   output ctrl_uloop_t                 ctrl_uloop_o,
   input  flags_uloop_t                flags_uloop_i,
   output logic                        cmd_valid_o,
   input  logic                        cmd_ready_i,
   output logic [NB_REG*REG_WIDTH-1:0] cmd_offs_o,
   output logic [NB_LOOPS-1:0]         cmd_idx_update_o,
   output logic                        cmd_last_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        error_o
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

   uloop_master_state_t r_state;
   uloop_master_state_t w_state_next;

   logic             w_fifo_push;
   logic             w_fifo_pop;
   logic             w_fifo_valid;
   logic             w_fifo_full;
   logic [CNT_W-1:0] w_fifo_count;
   uloop_cmd_t       w_push_cmd;
   uloop_cmd_t       w_head_cmd;
   logic             w_req_ok;
   logic             w_timeout;
   logic             w_error;
   logic             w_unused;

   assign w_req_ok = (w_fifo_count < CNT_W'(FIFO_DEPTH)) &&
                     ((SHADOWED == 0) || flags_uloop_i.ready);

`ifdef HWPE_CTRL_ULOOP_MASTER_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] r_wait_cnt;
   logic            r_error;

   // WAIT-cycle counter; held at zero outside WAIT so each entry starts fresh.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                r_wait_cnt <= '0;
      else if (r_state != WAIT)   r_wait_cnt <= '0;
      else                        r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   assign w_timeout = (r_state == WAIT) && !flags_uloop_i.valid && !flags_uloop_i.done &&
                      (r_wait_cnt == TO_W'(TIMEOUT_CYCLES-1));

   // Sticky watchdog error, cleared by a soft clear or an accepted start.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                              r_error <= 1'b0;
      else if (clear_i)                         r_error <= 1'b0;
      else if ((r_state == IDLE) && start_i)    r_error <= 1'b0;
      else if (w_timeout)                       r_error <= 1'b1;
   end

   assign w_error = r_error;
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

   assign w_timeout = 1'b0;
   assign w_error   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state logic; a soft clear overrides everything.
   always_comb begin
      w_state_next = r_state;
      if (clear_i) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (start_i) w_state_next = INIT;
            INIT:    w_state_next = REQ;
            REQ:     if (w_req_ok) w_state_next = WAIT;
            WAIT: begin
               if (flags_uloop_i.done || w_timeout) w_state_next = DRAIN;
               else if (flags_uloop_i.valid)        w_state_next = REQ;
            end
            DRAIN:   if (!w_fifo_valid) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   // uloop control outputs.
   always_comb begin
      ctrl_uloop_o        = '0;
      ctrl_uloop_o.enable = (r_state == REQ) && w_req_ok && !clear_i;
      ctrl_uloop_o.clear  = clear_i || (r_state == INIT) || (r_state == DONE);
      ctrl_uloop_o.ready  = (r_state != IDLE);
   end

   assign w_fifo_push = !clear_i && (r_state == WAIT) &&
                        (flags_uloop_i.valid || flags_uloop_i.done || w_timeout);
   assign w_fifo_pop  = w_fifo_valid && cmd_ready_i;

   // Command built from the sampled flags; a watchdog command carries zero payload.
   always_comb begin
      w_push_cmd = '0;
      if (!w_timeout) begin
         for (int unsigned i = 0; i < NB_REG; i++) begin
            w_push_cmd.offs[i][REG_WIDTH-1:0] = flags_uloop_i.offs[i][REG_WIDTH-1:0];
         end
         w_push_cmd.idx_update[NB_LOOPS-1:0] = flags_uloop_i.idx_update[NB_LOOPS-1:0];
      end
      w_push_cmd.last = flags_uloop_i.done | w_timeout;
   end

   hwpe_ctrl_uloop_cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) i_cmd_fifo (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_clear (clear_i),
      .i_push  (w_fifo_push),
      .i_data  (w_push_cmd),
      .i_pop   (w_fifo_pop),
      .o_valid (w_fifo_valid),
      .o_full  (w_fifo_full),
      .o_count (w_fifo_count),
      .o_data  (w_head_cmd)
   );

   // Flatten the head command onto the stream outputs.
   always_comb begin
      cmd_offs_o = '0;
      for (int unsigned i = 0; i < NB_REG; i++) begin
         cmd_offs_o[i*REG_WIDTH +: REG_WIDTH] = w_head_cmd.offs[i][REG_WIDTH-1:0];
      end
   end

   assign cmd_idx_update_o = w_head_cmd.idx_update[NB_LOOPS-1:0];
   assign cmd_last_o       = w_head_cmd.last;
   assign cmd_valid_o      = w_fifo_valid;
   assign busy_o           = (r_state != IDLE);
   assign done_o           = (r_state == DONE);
   assign error_o          = w_error;

   assign w_unused = ^{test_mode_i, flags_uloop_i, w_head_cmd, w_fifo_full};

endmodule

// File: tb/tb_hwpe_ctrl_uloop_master.sv
module tb_hwpe_ctrl_uloop_master;
   import hwpe_ctrl_package::*;

   localparam int unsigned NB_REG         = ULOOP_MAX_NB_REG;
   localparam int unsigned REG_WIDTH      = ULOOP_MAX_REG_WIDTH;
   localparam int unsigned NB_LOOPS       = ULOOP_MAX_NB_LOOPS;
   localparam int unsigned FIFO_DEPTH     = 4;
   localparam int unsigned TIMEOUT_CYCLES = 8;

   typedef struct packed {
      logic [NB_REG*REG_WIDTH-1:0] offs;
      logic [NB_LOOPS-1:0]         idx;
      logic                        last;
   } item_t;

   logic                        clk;
   logic                        rst_n;
   logic                        test_mode;
   logic                        clear;
   logic                        start;
   ctrl_uloop_t                 ctrl;
   flags_uloop_t                flags;
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic [NB_REG*REG_WIDTH-1:0] cmd_offs;
   logic [NB_LOOPS-1:0]         cmd_idx;
   logic                        cmd_last;
   logic                        busy;
   logic                        done;
   logic                        error;

   int n_checks = 0;
   int n_errors = 0;
   int n_pops   = 0;

   // uloop model state
   logic                        m_valid, m_done, m_fready, m_pend, m_mute;
   logic [NB_REG*REG_WIDTH-1:0] m_offs;
   logic [NB_LOOPS-1:0]         m_idx;
   item_t                       m_item;
   int                          m_cnt;
   int                          m_lat;
   item_t                       m_script[$];
   item_t                       exp_q[$];
   item_t                       mon_e;

   hwpe_ctrl_uloop_master #(
      .NB_REG         (NB_REG),
      .REG_WIDTH      (REG_WIDTH),
      .NB_LOOPS       (NB_LOOPS),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .SHADOWED       (1),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .test_mode_i      (test_mode),
      .clear_i          (clear),
      .start_i          (start),
      .ctrl_uloop_o     (ctrl),
      .flags_uloop_i    (flags),
      .cmd_valid_o      (cmd_valid),
      .cmd_ready_i      (cmd_ready),
      .cmd_offs_o       (cmd_offs),
      .cmd_idx_update_o (cmd_idx),
      .cmd_last_o       (cmd_last),
      .busy_o           (busy),
      .done_o           (done),
      .error_o          (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic item_t make_item(input logic [31:0] v, input logic last);
      item_t it;
      it = '0;
      for (int i = 0; i < int'(NB_REG); i++)
         it.offs[i*REG_WIDTH +: REG_WIDTH] = REG_WIDTH'(v + 32'(i) * 32'h100);
      it.idx  = NB_LOOPS'(v >> 4);
      it.last = last;
      return it;
   endfunction

   always_comb begin
      flags            = '0;
      flags.valid      = m_valid;
      flags.done       = m_done;
      flags.ready      = m_fready;
      flags.idx_update = m_idx;
      for (int i = 0; i < int'(NB_REG); i++)
         flags.offs[i] = m_offs[i*REG_WIDTH +: REG_WIDTH];
   end

   // uloop model: answers each enable after m_lat cycles with the next scripted iteration
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_done  <= 1'b0;
         m_pend  <= 1'b0;
         m_cnt   <= 0;
         m_offs  <= '0;
         m_idx   <= '0;
         m_item  <= '0;
      end else begin
         m_valid <= 1'b0;
         m_done  <= 1'b0;
         if (clear) begin
            m_pend <= 1'b0;
         end else if (m_pend) begin
            if (m_cnt <= 1) begin
               m_valid <= 1'b1;
               m_done  <= m_item.last;
               m_offs  <= m_item.offs;
               m_idx   <= m_item.idx;
               exp_q.push_back(m_item);
               m_pend  <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end else if (ctrl.enable && !m_mute && m_script.size() > 0) begin
            if (m_lat == 0) begin
               m_valid <= 1'b1;
               m_done  <= m_script[0].last;
               m_offs  <= m_script[0].offs;
               m_idx   <= m_script[0].idx;
               exp_q.push_back(m_script[0]);
            end else begin
               m_item <= m_script[0];
               m_pend <= 1'b1;
               m_cnt  <= m_lat;
            end
            m_script.delete(0);
         end
      end
   end

   // Scoreboard: every accepted command must match the oldest expected one
   always @(negedge clk) begin
      if (rst_n && cmd_valid && cmd_ready) begin
         n_pops++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL cmd_unexpected: got offs0=%h last=%b, required no command",
                     cmd_offs[REG_WIDTH-1:0], cmd_last);
         end else begin
            mon_e = exp_q.pop_front();
            if ({cmd_offs, cmd_idx, cmd_last} !== {mon_e.offs, mon_e.idx, mon_e.last}) begin
               n_errors++;
               $display("FAIL cmd_data: got offs=%h idx=%h last=%b, required offs=%h idx=%h last=%b",
                        cmd_offs, cmd_idx, cmd_last, mon_e.offs, mon_e.idx, mon_e.last);
            end
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({cmd_valid, busy, done, error, ctrl, cmd_last, cmd_offs, cmd_idx} !== '0) begin
         n_errors++;
         $display("FAIL reset_during: got valid=%b busy=%b done=%b err=%b ctrl=%b, required all 0",
                  cmd_valid, busy, done, error, ctrl);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({cmd_valid, busy, done, error, ctrl, cmd_last, cmd_offs, cmd_idx} !== '0) begin
         n_errors++;
         $display("FAIL reset_after: got valid=%b busy=%b done=%b err=%b ctrl=%b, required all 0",
                  cmd_valid, busy, done, error, ctrl);
      end
   endtask

   task automatic test_basic();
      int p0, n_done, n_clr;
      p0 = n_pops; n_done = 0; n_clr = 0;
      cmd_ready = 1'b1; m_fready = 1'b1; m_lat = 0;
      m_script.push_back(make_item(32'h10, 1'b0));
      m_script.push_back(make_item(32'h20, 1'b0));
      m_script.push_back(make_item(32'h30, 1'b1));
      pulse_start();
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done) n_done++;
         if (ctrl.clear) n_clr++;
      end
      n_checks++;
      if (n_done != 1) begin n_errors++; $display("FAIL basic_done: got %0d pulses, required 1", n_done); end
      n_checks++;
      if (n_clr != 2) begin n_errors++; $display("FAIL basic_clear: got %0d cycles, required 2", n_clr); end
      n_checks++;
      if (n_pops - p0 != 3 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL basic_count: got %0d cmds (%0d left), required 3 (0 left)", n_pops - p0, exp_q.size());
      end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy: got %b, required 0", busy); end
   endtask

   task automatic test_back_pressure();
      int p0, n_en;
      logic head_bad, seen_done;
      p0 = n_pops; n_en = 0; head_bad = 1'b0; seen_done = 1'b0;
      cmd_ready = 1'b0; m_fready = 1'b1; m_lat = 0;
      for (int v = 1; v <= 7; v++) m_script.push_back(make_item(32'(v) * 32'h10, v == 7));
      pulse_start();
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (ctrl.enable) n_en++;
         if (cmd_valid && cmd_offs[REG_WIDTH-1:0] !== 32'h10) head_bad = 1'b1;
      end
      n_checks++;
      if (n_en != 4) begin n_errors++; $display("FAIL bp_enables: got %0d, required 4", n_en); end
      n_checks++;
      if (head_bad || cmd_valid !== 1'b1 || cmd_offs[REG_WIDTH-1:0] !== 32'h10) begin
         n_errors++;
         $display("FAIL bp_head: got valid=%b offs0=%h unstable=%b, required 1/00000010/0",
                  cmd_valid, cmd_offs[REG_WIDTH-1:0], head_bad);
      end
      @(posedge clk); #1 cmd_ready = 1'b1;
      for (int k = 0; k < 60 && !seen_done; k++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      n_checks++;
      if (!seen_done || n_pops - p0 != 7 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL bp_drain: got done=%b cmds=%0d left=%0d, required 1/7/0",
                  seen_done, n_pops - p0, exp_q.size());
      end
   endtask

   task automatic test_shadowed();
      int p0, n_en;
      logic seen_done;
      p0 = n_pops; n_en = 0; seen_done = 1'b0;
      cmd_ready = 1'b1; m_fready = 1'b0; m_lat = 0;
      m_script.push_back(make_item(32'h40, 1'b1));
      pulse_start();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ctrl.enable) n_en++;
      end
      n_checks++;
      if (n_en != 0) begin n_errors++; $display("FAIL shadow_gate: got %0d enables, required 0", n_en); end
      @(posedge clk); #1 m_fready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ctrl.enable !== 1'b1) begin n_errors++; $display("FAIL shadow_first: got enable=%b, required 1", ctrl.enable); end
      for (int k = 0; k < 20 && !seen_done; k++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      n_checks++;
      if (!seen_done || n_pops - p0 != 1) begin
         n_errors++;
         $display("FAIL shadow_run: got done=%b cmds=%0d, required 1/1", seen_done, n_pops - p0);
      end
   endtask

   task automatic test_push_pop();
      int p0, consec, done_k;
      logic prev;
      p0 = n_pops; consec = 0; done_k = -1; prev = 1'b0;
      cmd_ready = 1'b1; m_fready = 1'b1; m_lat = 0;
      for (int v = 1; v <= 8; v++) m_script.push_back(make_item(32'h100 + 32'(v), v == 8));
      pulse_start();
      for (int k = 0; k < 22 && done_k < 0; k++) begin
         @(negedge clk);
         if (cmd_valid && prev) consec++;
         prev = cmd_valid;
         if (done) done_k = k;
      end
      n_checks++;
      if (consec != 0) begin n_errors++; $display("FAIL pp_occupancy: got %0d back-to-back valid cycles, required 0", consec); end
      n_checks++;
      if (done_k < 0) begin n_errors++; $display("FAIL pp_throughput: got no done within 22 cycles, required done"); end
      n_checks++;
      if (n_pops - p0 != 8 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL pp_count: got %0d cmds (%0d left), required 8 (0 left)", n_pops - p0, exp_q.size());
      end
   endtask

   task automatic test_clear_mid();
      int p0, n_en;
      logic seen_done;
      n_en = 0; seen_done = 1'b0;
      cmd_ready = 1'b0; m_fready = 1'b1; m_lat = 3;
      for (int v = 1; v <= 5; v++) m_script.push_back(make_item(32'h200 + 32'(v), 1'b0));
      pulse_start();
      for (int k = 0; k < 40 && n_en < 3; k++) begin
         @(negedge clk);
         if (ctrl.enable) n_en++;
      end
      n_checks++;
      if (n_en != 3) begin n_errors++; $display("FAIL clr_setup: got %0d enables, required 3", n_en); end
      @(posedge clk); #1 clear = 1'b1;
      exp_q.delete();
      m_script.delete();
      @(negedge clk);
      n_checks++;
      if (ctrl.clear !== 1'b1 || cmd_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL clr_cycle: got clear=%b valid=%b, required 1/1", ctrl.clear, cmd_valid);
      end
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cmd_valid !== 1'b0 || busy !== 1'b0 || ctrl !== '0) begin
         n_errors++;
         $display("FAIL clr_after: got valid=%b busy=%b ctrl=%b, required 0/0/000", cmd_valid, busy, ctrl);
      end
      p0 = n_pops;
      m_lat = 0; cmd_ready = 1'b1;
      m_script.push_back(make_item(32'h50, 1'b0));
      m_script.push_back(make_item(32'h60, 1'b1));
      pulse_start();
      for (int k = 0; k < 30 && !seen_done; k++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      n_checks++;
      if (!seen_done || n_pops - p0 != 2 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL clr_restart: got done=%b cmds=%0d left=%0d, required 1/2/0",
                  seen_done, n_pops - p0, exp_q.size());
      end
   endtask

`ifdef HWPE_CTRL_ULOOP_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      int p0, en_k, err_k, n_done;
      p0 = n_pops; en_k = -1; err_k = -1; n_done = 0;
      cmd_ready = 1'b1; m_fready = 1'b1; m_mute = 1'b1;
      exp_q.push_back(make_item(32'h0, 1'b1) & item_t'({{(NB_REG*REG_WIDTH+NB_LOOPS){1'b0}}, 1'b1}));
      pulse_start();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ctrl.enable && en_k < 0) en_k = k;
         if (error && err_k < 0) err_k = k;
         if (done) n_done++;
      end
      n_checks++;
      if (en_k < 0 || err_k - en_k != int'(TIMEOUT_CYCLES) + 1) begin
         n_errors++;
         $display("FAIL to_latency: got error %0d cycles after enable, required %0d", err_k - en_k, TIMEOUT_CYCLES + 1);
      end
      n_checks++;
      if (n_done != 1 || error !== 1'b1) begin
         n_errors++;
         $display("FAIL to_done: got done pulses=%0d error=%b, required 1/1", n_done, error);
      end
      n_checks++;
      if (n_pops - p0 != 1 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL to_cmd: got %0d cmds (%0d left), required 1 (0 left)", n_pops - p0, exp_q.size());
      end
      m_mute = 1'b0;
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      n_checks++;
      if (error !== 1'b0) begin n_errors++; $display("FAIL to_clear: got error=%b, required 0", error); end
   endtask
`else
   task automatic test_no_timeout();
      n_checks++;
      if (error !== 1'b0) begin n_errors++; $display("FAIL err_tied: got error=%b, required 0", error); end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "global timeout");
   end

   initial begin
      rst_n = 1'b0; test_mode = 1'b0; clear = 1'b0; start = 1'b0;
      cmd_ready = 1'b0; m_fready = 1'b1; m_mute = 1'b0; m_lat = 0;
      test_reset();
      test_basic();
      test_back_pressure();
      test_shadowed();
      test_push_pop();
      test_clear_mid();
`ifdef HWPE_CTRL_ULOOP_MASTER_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hwpe_ctrl_uloop_master.md
Name: hwpe_ctrl_uloop_master

Overview:
- Initiator side of the uloop control interface. Drives `ctrl_uloop_t` (enable/clear/ready) and consumes `flags_uloop_t` (valid/done/ready/offs/idx/idx_update).
- Turns each produced iteration into a buffered command (offsets, index-update mask, last flag). Commands go out on a valid/ready stream toward the streamer address generators.
- Sits between the engine FSM and the streamers. Replaces hand-written enable/clear sequencing in each accelerator.

Parameters:
- NB_REG, `hwpe_ctrl_package::ULOOP_MAX_NB_REG`, number of offset registers forwarded per command.
- REG_WIDTH, `hwpe_ctrl_package::ULOOP_MAX_REG_WIDTH`, width of each forwarded offset.
- NB_LOOPS, `hwpe_ctrl_package::ULOOP_MAX_NB_LOOPS`, number of forwarded `idx_update` bits.
- FIFO_DEPTH, 4, command buffer depth; must be at least 2.
- SHADOWED, `hwpe_ctrl_package::ULOOP_DEFAULT_SHADOWED`, 1 = issue enable only when `flags_uloop_i.ready`=1.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low (already decided; one clock).
- test_mode_i  in  1  unused functionally.
- clear_i  in  1  synchronous soft clear.
- start_i  in  1  one-cycle start pulse.
- ctrl_uloop_o  out  `ctrl_uloop_t`  enable/clear/ready toward the uloop.
- flags_uloop_i  in  `flags_uloop_t`  flags from the uloop.
- cmd_valid_o  out  1  command stream valid.
- cmd_ready_i  in  1  command stream ready.
- cmd_offs_o  out  NB_REG*REG_WIDTH  offsets of the head command.
- cmd_idx_update_o  out  NB_LOOPS  `idx_update` of the head command.
- cmd_last_o  out  1  head command is the final one.
- busy_o  out  1  high from start acceptance until DONE is left.
- done_o  out  1  one-cycle pulse at end of sequence.
- error_o  out  1  sticky watchdog error; tied to 0 without the optional feature.

Behaviour:
- Reset / clear values: all outputs 0, FSM in IDLE, FIFO empty.
- `clear_i` in any state: FSM to IDLE, FIFO flushed, `error_o` cleared. `ctrl_uloop_o.clear`=1 in that same cycle (combinational from `clear_i`).
- `ctrl_uloop_o.ready` = 1 whenever FSM is not IDLE.
- IDLE:
  - `start_i`=1 -> INIT. `start_i` is ignored in every other state.
- INIT:
  - `ctrl_uloop_o.clear`=1 for exactly one cycle, then -> REQ.
- REQ:
  - Condition: FIFO count < FIFO_DEPTH, and (SHADOWED=0 or `flags_uloop_i.ready`=1).
  - When the condition holds: `ctrl_uloop_o.enable`=1 for exactly one cycle, -> WAIT.
  - Otherwise hold in REQ with enable=0.
- WAIT:
  - Enable=0. Sample `flags_uloop_i` every cycle.
  - `valid`=1 and `done`=0: push {offs[NB_REG-1:0], idx_update[NB_LOOPS-1:0], last=0}, -> REQ.
  - `done`=1 (with or without `valid`): push {offs, idx_update, last=1}, -> DRAIN.
- DRAIN:
  - Wait until FIFO empty and no handshake pending, then -> DONE.
- DONE:
  - `done_o`=1 and `ctrl_uloop_o.clear`=1 for one cycle, -> IDLE.
- At most one enable is outstanding. A push never hits a full FIFO by construction. An overflow is an assertion failure.
- FIFO:
  - First-word-fall-through. `cmd_valid_o` = FIFO not empty.
  - Pop on `cmd_valid_o` & `cmd_ready_i`.
  - Push and pop in the same cycle: count unchanged.
  - Head data stays stable while `cmd_valid_o`=1 and `cmd_ready_i`=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is `$clog2(FIFO_DEPTH+1)`.
- Latency: the first command is visible at earliest 1 cycle after the cycle in which flags `valid` is sampled (registered FIFO write).

Optional Feature:
- Macro: `HWPE_CTRL_ULOOP_MASTER_TIMEOUT_EN`.
- With the macro:
  - A counter runs in WAIT and resets on entry to WAIT.
  - If TIMEOUT_CYCLES cycles pass with neither `valid` nor `done`: set `error_o` (sticky until `clear_i` or the next `start_i`), push a last=1 command with offsets 0, -> DRAIN.
- Without the macro:
  - No counter. `error_o`=0. WAIT waits indefinitely.

Decomposition:
- `hwpe_ctrl_package` gets:
  - typedef `uloop_cmd_t` {offs[ULOOP_MAX_NB_REG], idx_update[ULOOP_MAX_NB_LOOPS], last}.
  - FSM state enum `uloop_master_state_t` {IDLE, INIT, REQ, WAIT, DRAIN, DONE}.
- Sub-module `hwpe_ctrl_uloop_cmd_fifo`: parametric FWFT FIFO of `uloop_cmd_t`, same clock/reset/clear.

Test Plan:
- Basic run:
  - Stimulus: `start_i`, uloop model returns valid with offs[0]=0x10, 0x20, then done with offs[0]=0x30; `cmd_ready_i`=1.
  - Response: exactly 3 commands 0x10/0x20/0x30 in order, last=1 only on 0x30. `done_o` pulses once. `ctrl_uloop_o.clear` pulses in INIT and in DONE.
- Back-pressure:
  - Stimulus: FIFO_DEPTH=4, `cmd_ready_i`=0, model returns 6 iterations then done.
  - Response: after 4 pushes `enable` stays 0. Head holds 0x10. When ready is released, all 7 commands drain in order with no loss.
- Shadowed gating:
  - Stimulus: SHADOWED=1, `flags.ready`=0 for 5 cycles, then 1.
  - Response: no enable during those 5 cycles. Enable is asserted in the first cycle ready=1.
- Simultaneous push/pop:
  - Stimulus: `cmd_ready_i`=1 and flags valid arriving every other cycle.
  - Response: count never exceeds 1, throughput sustained, no duplicated command.
- Clear mid-operation:
  - Stimulus: `clear_i` in WAIT with 2 entries buffered.
  - Response: `cmd_valid_o`=0 the next cycle, `busy_o`=0, clear=1 that cycle. A new `start_i` runs normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8):
  - Stimulus: model never responds.
  - Response: `error_o`=1 after 8 WAIT cycles, one last=1 command with offs=0, then `done_o` pulses.
